// File: rtl/avg_obuf.sv
// Output elastic buffer for the moving-average datapath.
// A first-word-fall-through FIFO captures every qualified averager word and
// lets a slower consumer drain it through a valid/ack handshake. Words that
// arrive while the FIFO is full and not being drained are dropped. Drops are
// reported through a sticky flag and a saturating drop counter.
module avg_obuf #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ack,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [AW:0] FullCnt = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [7:0]    drop_cnt_q;

  logic pop, push, drop;

  // Handshake decode; a pop frees the slot that a push into a full FIFO uses.
  always_comb begin
    pop  = ~empty & out_ack;
    push = din_vld & (~full | pop);
    drop = din_vld & full & ~pop;
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW + 1)'(1);
      end
    end
  end

  // Overflow reporting; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (ovf_clr) begin
        drop_cnt_q <= 8'd1;
      end else if (drop_cnt_q != 8'hff) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    out_data  = mem_q[rd_ptr_q];
    count     = count_q;
    full      = (count_q == FullCnt);
    empty     = (count_q == '0);
    out_valid = ~empty;
    ovf       = ovf_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_avg_obuf.sv
// Self-checking bench for avg_obuf: a queue scoreboard tracks accepted words
// and overflow state; a small vector table covers fall-through ordering.
module tb_avg_obuf;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        din_vld;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ack;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  avg_obuf #(.DW(16), .AW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_vld  (din_vld),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] sb[$];
  logic        m_ovf;
  int          m_drop;

  typedef struct {
    logic        vld;
    logic [15:0] d;
    logic        ack;
    logic        clr;
    int          exp_count;
    logic [15:0] exp_head;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(sb.size()));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == 16));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (sb.size() != 0) chk("head", 32'(out_data), 32'(sb[0]));
  endtask

  // One clock with the given inputs; scoreboard updated, state checked after.
  task automatic cycle(input logic vld, input logic [15:0] d, input logic ack,
                       input logic clr);
    bit f_pop, f_full, f_push, f_drop;
    din_vld = vld;
    din     = d;
    out_ack = ack;
    ovf_clr = clr;
    f_pop  = (sb.size() != 0) && ack;
    f_full = (sb.size() == 16);
    f_push = vld && (!f_full || f_pop);
    f_drop = vld && f_full && !f_pop;
    if (f_pop) begin
      chk("pop_data", 32'(out_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (f_push) sb.push_back(d);
    if (f_drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input int cycles, input logic vld, input logic ack);
    reset   = 1'b0;
    din_vld = vld;
    din     = 16'hdead;
    out_ack = ack;
    ovf_clr = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset   = 1'b1;
    din_vld = 1'b0;
    out_ack = 1'b0;
    sb.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  initial begin
    reset   = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    out_ack = 1'b0;
    ovf_clr = 1'b0;
    m_ovf   = 1'b0;
    m_drop  = 0;

    // Fall-through order, simultaneous push/ack on empty, idle clear.
    tbl[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 1, 16'h0010};
    tbl[1] = '{1'b1, 16'h0020, 1'b0, 1'b0, 2, 16'h0010};
    tbl[2] = '{1'b1, 16'h0030, 1'b0, 1'b0, 3, 16'h0010};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h0020};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0030};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000};
    tbl[6] = '{1'b1, 16'hbeef, 1'b1, 1'b0, 1, 16'hbeef};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 16'h0000};

    // Reset then idle.
    do_reset(2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_drop", 32'(drop_cnt), 32'd0);
    end

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].vld, tbl[i].d, tbl[i].ack, tbl[i].clr);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      if (tbl[i].exp_count != 0) chk($sformatf("tbl%0d_head", i), 32'(out_data),
                                     32'(tbl[i].exp_head));
    end

    // Fill and overflow.
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 16) chk("full_at_16", 32'(full), 32'd1);
    end
    chk("ovf_after_fill", 32'(ovf), 32'd1);
    chk("drop4", 32'(drop_cnt), 32'd4);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_val", 32'(out_data), 32'(i));
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("drained_empty", 32'(empty), 32'd1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Full streaming with pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("stream_seq", 32'(out_data), 32'(16'h0100 + i));
      cycle(1'b1, 16'(16'h0110 + i), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'd16);
    end
    chk("stream_nodrop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Reset mid-operation.
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16'h0a00 + i), 1'b0, 1'b0);
    do_reset(1, 1'b1, 1'b1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("post_rst_head", 32'(out_data), 32'h1234);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Saturation, then clear coinciding with a drop.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h0c00 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'hffff, 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    cycle(1'b1, 16'hffff, 1'b0, 1'b0);
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    cycle(1'b1, 16'hffff, 1'b0, 1'b1);
    chk("clr_drop_wins_cnt", 32'(drop_cnt), 32'd1);
    chk("clr_drop_wins_ovf", 32'(ovf), 32'd1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("final_clr", 32'(drop_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
